// File: rtl/beehive_tx_framer_pkg.sv
// Shared types and helpers for the Beehive MAC TX to AXI-Stream framer.
package beehive_tx_framer_pkg;

    localparam int MAC_IF_W      = 512;
    localparam int MAC_KEEP_W    = MAC_IF_W / 8;
    localparam int MAC_PAD_W     = $clog2(MAC_KEEP_W);
    localparam int MTU_SIZE_W    = 16;
    localparam int TX_USER_W_DEF = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } framer_state_e;

    // One AXIS beat as held in the output skid buffer.
    typedef struct packed {
        logic [MAC_IF_W-1:0]      data;
        logic [MAC_KEEP_W-1:0]    keep;
        logic                     last;
        logic [TX_USER_W_DEF-1:0] user;
    } tx_beat_t;

    // Valid-byte mask for a beat with 'pad' invalid trailing bytes (low bytes kept).
    function automatic logic [MAC_KEEP_W-1:0] pad_to_keep(input logic [MAC_PAD_W-1:0] pad);
        return {MAC_KEEP_W{1'b1}} >> pad;
    endfunction

    // Engine carries byte 0 in the MSBs, AXIS carries byte 0 in the LSBs.
    function automatic logic [MAC_IF_W-1:0] byte_reverse(input logic [MAC_IF_W-1:0] d);
        logic [MAC_IF_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAC_KEEP_W; i++) begin
            r[8*i +: 8] = d[8*(MAC_KEEP_W-1-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/beehive_tx_axis_framer_skid.sv
// Generic 2-entry valid/ready skid buffer with a registered input ready.
// Entry 0 is always the head, so the output payload comes straight from a flop
// and holds still while the consumer stalls.
module axis_skid_buf_2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid_i,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             s_ready_o,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    input  logic             m_ready_i
);

    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
    logic             rdy_q, rdy_d;
    logic             push, pop;

    assign push      = s_valid_i & rdy_q;
    assign pop       = m_ready_i & (cnt_q != 2'd0);
    assign s_ready_o = rdy_q;
    assign m_valid_o = (cnt_q != 2'd0);
    assign m_data_o  = mem0_q;

    // Next occupancy/contents; ready looks ahead at the post-edge occupancy.
    always_comb begin
        cnt_d  = cnt_q;
        mem0_d = mem0_q;
        mem1_d = mem1_q;
        unique case ({push, pop})
            2'b01: begin
                mem0_d = mem1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b10: begin
                if (cnt_q == 2'd0) mem0_d = s_data_i;
                else               mem1_d = s_data_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    mem0_d = s_data_i;
                end else begin
                    mem0_d = mem1_q;
                    mem1_d = s_data_i;
                end
            end
            default: ;
        endcase
        rdy_d = (cnt_d < 2'd2);
    end

    // Buffer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            mem0_q <= '0;
            mem1_q <= '0;
            rdy_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mem0_q <= mem0_d;
            mem1_q <= mem1_d;
            rdy_q  <= rdy_d;
        end
    end

endmodule

// File: rtl/beehive_tx_axis_framer.sv
// Beehive MAC TX -> AXI-Stream TX framer: byte reversal, tkeep from pad count,
// length policing against the declared frame size, orphan-beat discard.
module beehive_tx_axis_framer
    import beehive_tx_framer_pkg::*;
#(
    parameter int DATA_W    = MAC_IF_W,
    parameter int KEEP_W    = DATA_W / 8,
    parameter int PAD_W     = $clog2(KEEP_W),
    parameter int SIZE_W    = MTU_SIZE_W,
    parameter int TX_USER_W = TX_USER_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 src_tx_val_i,
    input  logic                 src_tx_startframe_i,
    input  logic [SIZE_W-1:0]    src_tx_frame_size_i,
    input  logic                 src_tx_endframe_i,
    input  logic [DATA_W-1:0]    src_tx_data_i,
    input  logic [PAD_W-1:0]     src_tx_padbytes_i,
    output logic                 src_tx_rdy_o,
    output logic [DATA_W-1:0]    m_axis_tdata_o,
    output logic [KEEP_W-1:0]    m_axis_tkeep_o,
    output logic                 m_axis_tvalid_o,
    input  logic                 m_axis_tready_i,
    output logic                 m_axis_tlast_o,
    output logic [TX_USER_W-1:0] m_axis_tuser_o,
    output logic                 len_err_o,
    output logic                 orphan_drop_o
);

    localparam logic [MTU_SIZE_W:0] BEAT_BYTES = (MTU_SIZE_W+1)'(MAC_KEEP_W);

    framer_state_e         state_q, state_d;
    logic [MTU_SIZE_W-1:0] size_q, size_d;
    logic [MTU_SIZE_W-1:0] cnt_q, cnt_d;
    logic                  len_err_q, len_err_d;
    logic                  orphan_q, orphan_d;

    logic                  accept, emit, mismatch;
    logic [MTU_SIZE_W-1:0] base_size, base_cnt, cnt_inc;
    logic [MTU_SIZE_W:0]   total, sum;
    tx_beat_t              beat_in, beat_out;

    assign accept = src_tx_val_i & src_tx_rdy_o;

    // A start beat in IDLE counts from zero against the live size input;
    // in FRAME use the latched values.
    always_comb begin
        base_size = (state_q == IDLE) ? src_tx_frame_size_i : size_q;
        base_cnt  = (state_q == IDLE) ? '0 : cnt_q;
        total     = {1'b0, base_cnt} + BEAT_BYTES
                    - {{(MTU_SIZE_W+1-MAC_PAD_W){1'b0}}, src_tx_padbytes_i};
        sum       = {1'b0, base_cnt} + BEAT_BYTES;
        // Saturated count makes total exceed any 16-bit size, forcing a mismatch.
        cnt_inc   = sum[MTU_SIZE_W] ? '1 : sum[MTU_SIZE_W-1:0];
        mismatch  = (total != {1'b0, base_size});
    end

    // Outgoing beat payload.
    always_comb begin
        beat_in      = '0;
        beat_in.data = byte_reverse(src_tx_data_i);
        beat_in.keep = src_tx_endframe_i ? pad_to_keep(src_tx_padbytes_i) : '1;
        beat_in.last = src_tx_endframe_i;
        beat_in.user[0] = src_tx_endframe_i & mismatch;
    end

    // Framing FSM next state, counters and event pulses.
    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        cnt_d     = cnt_q;
        emit      = 1'b0;
        len_err_d = 1'b0;
        orphan_d  = 1'b0;
        if (accept) begin
            if (state_q == IDLE && !src_tx_startframe_i) begin
                orphan_d = 1'b1;
            end else begin
                emit = 1'b1;
                if (state_q == IDLE) size_d = src_tx_frame_size_i;
                if (src_tx_endframe_i) begin
                    state_d   = IDLE;
                    len_err_d = mismatch;
                end else begin
                    state_d = FRAME;
                    cnt_d   = cnt_inc;
                end
            end
        end
    end

    // FSM and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            size_q    <= '0;
            cnt_q     <= '0;
            len_err_q <= 1'b0;
            orphan_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            size_q    <= size_d;
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
            orphan_q  <= orphan_d;
        end
    end

    axis_skid_buf_2 #(
        .WIDTH($bits(tx_beat_t))
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid_i (emit),
        .s_data_i  (beat_in),
        .s_ready_o (src_tx_rdy_o),
        .m_valid_o (m_axis_tvalid_o),
        .m_data_o  (beat_out),
        .m_ready_i (m_axis_tready_i)
    );

    assign m_axis_tdata_o = beat_out.data;
    assign m_axis_tkeep_o = beat_out.keep;
    assign m_axis_tlast_o = beat_out.last;
    assign m_axis_tuser_o = beat_out.user;
    assign len_err_o      = len_err_q;
    assign orphan_drop_o  = orphan_q;

endmodule

// File: tb/tb_beehive_tx_axis_framer.sv
// Randomized bench for beehive_tx_axis_framer with a queue-based frame model.
module tb_beehive_tx_axis_framer;

    localparam int DW = 512;
    localparam int KW = 64;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           val = 1'b0, sof = 1'b0, eof = 1'b0;
    logic [15:0]    fsize = '0;
    logic [DW-1:0]  din = '0;
    logic [5:0]     pad = '0;
    logic           rdy;
    logic [DW-1:0]  tdata;
    logic [KW-1:0]  tkeep;
    logic           tvalid, tlast, len_err, orphan;
    logic           tready = 1'b1;
    logic [0:0]     tuser;

    beehive_tx_axis_framer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .src_tx_val_i        (val),
        .src_tx_startframe_i (sof),
        .src_tx_frame_size_i (fsize),
        .src_tx_endframe_i   (eof),
        .src_tx_data_i       (din),
        .src_tx_padbytes_i   (pad),
        .src_tx_rdy_o        (rdy),
        .m_axis_tdata_o      (tdata),
        .m_axis_tkeep_o      (tkeep),
        .m_axis_tvalid_o     (tvalid),
        .m_axis_tready_i     (tready),
        .m_axis_tlast_o      (tlast),
        .m_axis_tuser_o      (tuser),
        .len_err_o           (len_err),
        .orphan_drop_o       (orphan)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [599:0] act, input logic [599:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- model state ----------------
    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    beat_t exp_q[$];
    bit    m_inframe = 0;
    int    m_size = 0, m_bytes = 0;
    bit    exp_len = 0, exp_orph = 0, armed = 0;
    bit    hold_prev = 0;
    beat_t prev_out;
    int    cyc = 0;
    int    len_pulses = 0, orph_pulses = 0;
    bit    rdy_low_seen = 0;
    beat_t last_out;
    bit    rec = 0;
    int    acc_cyc[$], out_cyc[$];
    int    tr_mode = 0, hold_cnt = 0;

    function automatic beat_t model_beat(input logic [DW-1:0] d, input bit last,
                                         input int p, input bit user);
        beat_t b;
        for (int i = 0; i < KW; i++) begin
            b.data[8*i +: 8] = d[8*(KW-1-i) +: 8];
            b.keep[i]        = last ? (i < KW - p) : 1'b1;
        end
        b.last = last;
        b.user = user;
        return b;
    endfunction

    // Cycle-by-cycle compare; everything sampled mid-cycle.
    always @(negedge clk) begin
        beat_t cur;
        cur = '{data: tdata, keep: tkeep, last: tlast, user: tuser[0]};
        if (!rst_n) begin
            exp_q.delete();
            m_inframe = 0; exp_len = 0; exp_orph = 0; armed = 0; hold_prev = 0;
        end else begin
            chk("src_tx_rdy", rdy, armed ? (exp_q.size() < 2) : 1'b0);
            armed = 1;
            if (!rdy) rdy_low_seen = 1;
            chk("len_err", len_err, exp_len);
            chk("orphan_drop", orphan, exp_orph);
            if (len_err) len_pulses++;
            if (orphan) orph_pulses++;
            chk("tvalid", tvalid, exp_q.size() != 0);
            if (hold_prev) chk("stall_stable", cur, prev_out);
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    chk("beat", cur, exp_q.pop_front());
                end
                last_out = cur;
                if (rec) out_cyc.push_back(cyc);
            end
            hold_prev = tvalid && !tready;
            prev_out  = cur;
            exp_len = 0; exp_orph = 0;
            if (val && rdy) begin
                if (!m_inframe && !sof) begin
                    exp_orph = 1;
                end else begin
                    bit mm;
                    if (!m_inframe) begin m_size = fsize; m_bytes = 0; end
                    mm = 0;
                    if (eof) begin
                        mm = (m_bytes + KW - int'(pad)) != m_size;
                        exp_len = mm;
                        m_inframe = 0;
                    end else begin
                        m_bytes += KW;
                        m_inframe = 1;
                    end
                    exp_q.push_back(model_beat(din, eof, int'(pad), mm));
                    if (rec) acc_cyc.push_back(cyc);
                end
            end
        end
        cyc++;
    end

    // Sink ready generator.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (hold_cnt > 0) begin tready = 1'b0; hold_cnt--; end
            else if (tr_mode == 0) tready = 1'b1;
            else tready = 1'($urandom_range(0, 1));
        end
    end

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW/32; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input bit s, input bit e, input logic [15:0] sz,
                             input logic [5:0] p, input logic [DW-1:0] d);
        bit done;
        val = 1'b1; sof = s; eof = e; fsize = sz; pad = p; din = d;
        done = 0;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            if (rdy) begin @(posedge clk); #1; done = 1; end
        end
        if (!done) chk("send_timeout", 1'b0, 1'b1);
        val = 1'b0;
    endtask

    task automatic send_frame(input int nb, input int sz, input int p);
        for (int b = 0; b < nb; b++)
            send_beat(b == 0, b == nb-1, (b == 0) ? 16'(sz) : 16'($urandom),
                      (b == nb-1) ? 6'(p) : 6'($urandom), rand_data());
    endtask

    task automatic drain();
        bit done = 0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !tvalid) done = 1;
        end
        chk("drain", done, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [DW-1:0] d1;
        int lp0, op0;
        #2;
        chk("reset_rdy", rdy, 1'b0);
        chk("reset_outs", {tvalid, tlast, tkeep, tuser, tdata, len_err, orphan}, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: single-beat frame, bytes 0..63 with byte 0 in MSBs
        for (int k = 0; k < KW; k++) d1[8*(KW-1-k) +: 8] = 8'(k);
        lp0 = len_pulses;
        send_beat(1, 1, 16'd60, 6'd4, d1);
        drain();
        chk("t1_keep", last_out.keep, 64'h0FFF_FFFF_FFFF_FFFF);
        chk("t1_byte0", last_out.data[7:0], 8'h00);
        chk("t1_byte1", last_out.data[15:8], 8'h01);
        chk("t1_byte63", last_out.data[511:504], 8'h3F);
        chk("t1_last_user", {last_out.last, last_out.user}, 2'b10);
        chk("t1_no_len_err", len_pulses - lp0, 0);

        // 2: three beats, size 150, pad 42, back-to-back
        acc_cyc.delete(); out_cyc.delete(); rec = 1;
        send_frame(3, 150, 42);
        drain();
        rec = 0;
        chk("t2_nout", out_cyc.size(), 3);
        if (acc_cyc.size() > 0 && out_cyc.size() == 3)
            for (int i = 0; i < 3; i++) chk("t2_latency", out_cyc[i], acc_cyc[0] + 1 + i);
        chk("t2_keep", last_out.keep, 64'h0000_0000_003F_FFFF);
        chk("t2_user", last_out.user, 1'b0);

        // 3: same frame, wrong size 160
        lp0 = len_pulses;
        send_frame(3, 160, 42);
        drain();
        chk("t3_user", last_out.user, 1'b1);
        chk("t3_len_pulses", len_pulses - lp0, 1);

        // 4: backpressure for 5 cycles mid-frame
        rdy_low_seen = 0;
        fork
            send_frame(6, 6*64 - 10, 10);
            begin repeat (2) @(posedge clk); #2 hold_cnt = 5; end
        join
        drain();
        chk("t4_rdy_low", rdy_low_seen, 1'b1);

        // 5: orphan beat in IDLE, then a clean frame
        op0 = orph_pulses;
        send_beat(0, 0, 16'd99, 6'd0, rand_data());
        send_frame(2, 128, 0);
        drain();
        chk("t5_orphan_pulses", orph_pulses - op0, 1);
        chk("t5_user", last_out.user, 1'b0);

        // 6: reset mid-frame with beats parked in the buffer
        hold_cnt = 20;
        send_beat(1, 0, 16'd256, 6'd0, rand_data());
        send_beat(0, 0, 16'd0, 6'd0, rand_data());
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_rdy", rdy, 1'b0);
        chk("t6_rst_outs", {tvalid, tlast, tkeep, tuser, tdata, len_err, orphan}, '0);
        @(negedge clk);
        hold_cnt = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send_frame(2, 100, 28);
        drain();
        chk("t6_keep", last_out.keep, 64'h0000_000F_FFFF_FFFF);
        chk("t6_user", last_out.user, 1'b0);

        // Random traffic: random sizes, pads, gaps, orphans and sink stalls
        tr_mode = 1;
        for (int f = 0; f < 60; f++) begin
            int nb, p, sz;
            nb = $urandom_range(1, 5);
            p  = $urandom_range(0, 63);
            sz = (nb - 1) * KW + KW - p;
            if ($urandom_range(0, 3) == 0) sz = $urandom_range(0, 400);
            if ($urandom_range(0, 9) == 0) send_beat(0, $urandom_range(0, 1), 16'($urandom), 6'($urandom), rand_data());
            send_frame(nb, sz, p);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        tr_mode = 0;
        drain();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
